// File: rtl/traffic_controller_multi_pkg.sv
// Shared definitions for the N-way traffic-light controller.
//   - Lamp codes driven per way on the signals bus.
//   - FSM state encoding, also visible on the state_dbg output.
package traffic_controller_multi_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_WALK   = 2'd3
  } state_t;

endpackage

// File: rtl/traffic_controller_multi_phase_timer.sv
// Phase timer for the traffic controller.
//   i_clk      : system clock, rising edge
//   i_rst_n    : asynchronous active-low reset, counter -> 0
//   i_clear    : reload the counter to 0 on the next edge
//   i_limit    : duration of the current phase in cycles (>=1)
//   o_terminal : high on the last cycle of the phase (cnt == i_limit-1)
module traffic_controller_multi_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_terminal = (r_cnt == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/traffic_controller_multi.sv
// N-way traffic-light controller with vehicle-sensor skipping, green hold
// and a pedestrian walk phase.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   car_present  : bit i = vehicle waiting at way i
//   ped_req      : pedestrian button (pulse or level)
//   signals      : lamp code for way i at [2i+1:2i]
//   active_way   : way owning green/yellow (last owner during all-red/walk)
//   walk         : pedestrian walk lamp
//   ped_pending  : latched walk request not yet served
//   state_dbg    : current FSM state
module traffic_controller_multi
  import traffic_controller_multi_pkg::*;
#(
  parameter int NUM_WAYS      = 2,
  parameter int GREEN_CYCLES  = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 3,
  parameter int CNT_W         = 8,
  parameter int SKIP_EMPTY    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WAYS-1:0]         car_present,
  input  logic                        ped_req,
  output logic [2*NUM_WAYS-1:0]       signals,
  output logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic                        walk,
  output logic                        ped_pending,
  output state_t                      state_dbg
);

  localparam int AW   = $clog2(NUM_WAYS);
  localparam bit SKIP = (SKIP_EMPTY != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_active_way;
  logic [AW-1:0]    w_active_nxt;
  logic [AW-1:0]    w_nxt_way;
  logic             r_ped_pending;
  logic             w_ped_nxt;
  logic [CNT_W-1:0] w_limit;
  logic             w_terminal;
  logic             w_other_car;
  logic             w_found;
  int               w_idx;

  // Duration of the phase currently being timed.
  always_comb begin
    case (r_state)
      S_GREEN:  w_limit = CNT_W'(GREEN_CYCLES);
      S_YELLOW: w_limit = CNT_W'(YELLOW_CYCLES);
      S_ALLRED: w_limit = CNT_W'(ALLRED_CYCLES);
      default:  w_limit = CNT_W'(WALK_CYCLES);
    endcase
  end

  // Every phase either ends or (green hold) restarts on its terminal cycle,
  // so the counter reloads exactly when the terminal flag is up.
  traffic_controller_multi_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_clear    (w_terminal),
    .i_limit    (w_limit),
    .o_terminal (w_terminal)
  );

  // Next-way search: nearest way after the current one that has a car,
  // the current way itself being examined last. Falls back to plain
  // round-robin when no car is waiting anywhere or skipping is disabled.
  always_comb begin
    w_nxt_way   = AW'((int'(r_active_way) + 1) % NUM_WAYS);
    w_found     = 1'b0;
    w_other_car = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if ((AW'(i) != r_active_way) && car_present[i]) begin
        w_other_car = 1'b1;
      end
    end
    if (SKIP) begin
      for (int k = 1; k <= NUM_WAYS; k++) begin
        w_idx = (int'(r_active_way) + k) % NUM_WAYS;
        if (!w_found && car_present[w_idx]) begin
          w_found   = 1'b1;
          w_nxt_way = AW'(w_idx);
        end
      end
    end
  end

  // FSM next state. Walk entry clears the pending request and wins over a
  // same-cycle ped_req; a request on any other exit edge is kept.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active_way;
    w_ped_nxt    = r_ped_pending | (ped_req && (r_state != S_WALK));
    if (w_terminal) begin
      case (r_state)
        S_GREEN: begin
          if (!(SKIP && !w_other_car && !r_ped_pending)) begin
            w_state_nxt = S_YELLOW;
          end
        end
        S_YELLOW: w_state_nxt = S_ALLRED;
        S_ALLRED: begin
          if (r_ped_pending) begin
            w_state_nxt = S_WALK;
            w_ped_nxt   = 1'b0;
          end else begin
            w_state_nxt  = S_GREEN;
            w_active_nxt = w_nxt_way;
          end
        end
        default: begin
          w_state_nxt  = S_GREEN;
          w_active_nxt = w_nxt_way;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_ALLRED;
      r_active_way  <= AW'(NUM_WAYS - 1);
      r_ped_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_active_way  <= w_active_nxt;
      r_ped_pending <= w_ped_nxt;
    end
  end

  // Lamp decode: only the active way can be lit, and only in green/yellow.
  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      signals[2*i +: 2] = LAMP_RED;
      if (AW'(i) == r_active_way) begin
        if (r_state == S_GREEN) begin
          signals[2*i +: 2] = LAMP_GREEN;
        end else if (r_state == S_YELLOW) begin
          signals[2*i +: 2] = LAMP_YELLOW;
        end
      end
    end
  end

  assign walk        = (r_state == S_WALK);
  assign active_way  = r_active_way;
  assign ped_pending = r_ped_pending;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_traffic_controller_multi.sv
module tb_traffic_controller_multi;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int WK = 3;

  // Phase codes of the reference model (values match the documented state codes).
  localparam int PH_GREEN  = 0;
  localparam int PH_YELLOW = 1;
  localparam int PH_ALLRED = 2;
  localparam int PH_WALK   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] car_present;
  logic       ped_req;

  logic [7:0] sig0;
  logic [1:0] aw0;
  logic       walk0, pend0;
  logic [1:0] st0;
  logic [3:0] sig1;
  logic [0:0] aw1;
  logic       walk1, pend1;
  logic [1:0] st1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Unit 0: 4 ways with sensor skipping. Unit 1: 2 ways, strict round-robin.
  traffic_controller_multi #(.NUM_WAYS(4), .SKIP_EMPTY(1)) dut0 (
    .clk(clk), .reset(reset), .car_present(car_present), .ped_req(ped_req),
    .signals(sig0), .active_way(aw0), .walk(walk0), .ped_pending(pend0), .state_dbg(st0)
  );

  traffic_controller_multi #(.NUM_WAYS(2), .SKIP_EMPTY(0)) dut1 (
    .clk(clk), .reset(reset), .car_present(car_present[1:0]), .ped_req(ped_req),
    .signals(sig1), .active_way(aw1), .walk(walk1), .ped_pending(pend1), .state_dbg(st1)
  );

  // ---------------- reference model ----------------
  int m_phase [2];
  int m_left  [2];   // cycles remaining in the current phase, including this one
  int m_way   [2];
  bit m_ped   [2];

  function automatic int ways(int u);
    return (u == 0) ? 4 : 2;
  endfunction

  function automatic bit skips(int u);
    return (u == 0);
  endfunction

  function automatic int pick_next(int u);
    int n = ways(u);
    if (skips(u)) begin
      for (int k = 1; k <= n; k++) begin
        int w;
        w = (m_way[u] + k) % n;
        if (car_present[w]) return w;
      end
    end
    return (m_way[u] + 1) % n;
  endfunction

  task automatic model_reset(int u);
    m_phase[u] = PH_ALLRED;
    m_left[u]  = AR;
    m_way[u]   = ways(u) - 1;
    m_ped[u]   = 1'b0;
  endtask

  task automatic model_step(int u);
    bit set_req;
    bit other;
    set_req = ped_req && (m_phase[u] != PH_WALK);
    if (m_left[u] > 1) begin
      m_left[u]--;
      m_ped[u] |= set_req;
    end else begin
      case (m_phase[u])
        PH_GREEN: begin
          other = 1'b0;
          for (int w = 0; w < ways(u); w++)
            if (w != m_way[u] && car_present[w]) other = 1'b1;
          if (skips(u) && !other && !m_ped[u]) begin
            m_left[u] = G;
          end else begin
            m_phase[u] = PH_YELLOW;
            m_left[u]  = Y;
          end
          m_ped[u] |= set_req;
        end
        PH_YELLOW: begin
          m_phase[u] = PH_ALLRED;
          m_left[u]  = AR;
          m_ped[u] |= set_req;
        end
        PH_ALLRED: begin
          if (m_ped[u]) begin
            m_phase[u] = PH_WALK;
            m_left[u]  = WK;
            m_ped[u]   = 1'b0;
          end else begin
            m_way[u]   = pick_next(u);
            m_phase[u] = PH_GREEN;
            m_left[u]  = G;
            m_ped[u] |= set_req;
          end
        end
        default: begin
          m_way[u]   = pick_next(u);
          m_phase[u] = PH_GREEN;
          m_left[u]  = G;
        end
      endcase
    end
  endtask

  function automatic logic [31:0] exp_signals(int u);
    logic [31:0] v = '0;
    for (int w = 0; w < ways(u); w++) begin
      if (w == m_way[u] && m_phase[u] == PH_GREEN)  v[2*w +: 2] = 2'b10;
      if (w == m_way[u] && m_phase[u] == PH_YELLOW) v[2*w +: 2] = 2'b01;
    end
    return v;
  endfunction

  function automatic bit lamps_safe(logic [31:0] v, int n);
    int lit = 0;
    for (int w = 0; w < n; w++) begin
      if (v[2*w +: 2] == 2'b11) return 1'b0;
      if (v[2*w +: 2] != 2'b00) lit++;
    end
    return (lit <= 1);
  endfunction

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    check("u0 signals", 32'(sig0), exp_signals(0));
    check("u0 active_way", 32'(aw0), 32'(m_way[0]));
    check("u0 walk", 32'(walk0), 32'(m_phase[0] == PH_WALK));
    check("u0 ped_pending", 32'(pend0), 32'(m_ped[0]));
    check("u0 state", 32'(st0), 32'(m_phase[0]));
    check("u0 safety", 32'(lamps_safe(32'(sig0), 4)), 32'd1);
    check("u1 signals", 32'(sig1), exp_signals(1));
    check("u1 active_way", 32'(aw1), 32'(m_way[1]));
    check("u1 walk", 32'(walk1), 32'(m_phase[1] == PH_WALK));
    check("u1 ped_pending", 32'(pend1), 32'(m_ped[1]));
    check("u1 state", 32'(st1), 32'(m_phase[1]));
    check("u1 safety", 32'(lamps_safe(32'(sig1), 2)), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set #1 after a rising edge; the model consumes them before the next edge.
  task automatic step();
    if (reset) begin
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_model(int u, int way, int ph, int budget, string tag);
    int k = 0;
    while (!(m_phase[u] == ph && (way < 0 || m_way[u] == way)) && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(m_phase[u] == ph && (way < 0 || m_way[u] == way)), 32'd1);
  endtask

  initial begin
    int t_first, t_second, lat;
    logic prev_g;
    bit bad_lit, saw3;

    reset = 1'b1; car_present = '0; ped_req = 1'b0;
    #1 reset = 1'b0;
    model_reset(0); model_reset(1);
    #1 compare_all();
    repeat (2) step();

    // Release with all cars waiting.
    reset = 1'b0;
    reset = 1'b1;
    car_present = 4'b1111;
    step();
    check("u0 first green way0", 32'(sig0), 32'h02);
    t_first = -1; t_second = -1; prev_g = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sig1[1:0] == 2'b10 && !prev_g) begin
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
      end
      prev_g = (sig1[1:0] == 2'b10);
    end
    check("u1 round-robin period", 32'(t_second - t_first), 32'd14);

    // Sensor skipping: only ways 0 and 3 have cars.
    car_present = 4'b1001;
    wait_model(0, 0, PH_GREEN, 60, "sync u0 way0 green");
    bad_lit = 1'b0; saw3 = 1'b0;
    repeat (40) begin
      step();
      if (sig0[3:2] != 2'b00 || sig0[5:4] != 2'b00) bad_lit = 1'b1;
      if (sig0[7:6] == 2'b10) saw3 = 1'b1;
    end
    check("skip ways 1,2 stay red", 32'(bad_lit), 32'd0);
    check("skip way3 served", 32'(saw3), 32'd1);

    // Green hold with a single demand, released by a second car.
    car_present = 4'b0001;
    wait_model(0, 0, PH_GREEN, 60, "sync u0 hold");
    repeat (20) step();
    check("green held", 32'(sig0), 32'h02);
    car_present = 4'b0011;
    lat = 0;
    while (sig0[1:0] != 2'b01 && lat < 10) begin
      step();
      lat++;
    end
    check("hold release latency", 32'(lat <= 4), 32'd1);

    // Pedestrian walk.
    car_present = 4'b1111;
    wait_model(0, 0, PH_GREEN, 60, "sync u0 ped");
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("ped latched", 32'(pend0), 32'd1);
    wait_model(0, -1, PH_WALK, 20, "walk entered");
    check("walk all red", 32'(sig0), 32'h00);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("ped in walk ignored", 32'(pend0), 32'd0);
    wait_model(0, 1, PH_GREEN, 4, "way1 green after walk");

    // Randomized traffic.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) car_present = 4'($urandom_range(0, 15));
      ped_req = ($urandom_range(0, 19) == 0);
      step();
    end
    ped_req = 1'b0;

    // Asynchronous reset in the middle of yellow.
    car_present = 4'b1111;
    wait_model(0, -1, PH_YELLOW, 60, "sync u0 yellow");
    #2 reset = 1'b0;
    model_reset(0); model_reset(1);
    #1;
    check("async reset lamps", 32'(sig0), 32'h00);
    check("async reset walk", 32'(walk0), 32'd0);
    compare_all();
    @(posedge clk); #1;
    compare_all();
    reset = 1'b1;
    step();
    check("reset way0 first green", 32'(sig0), 32'h02);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
